// File: rtl/module_7seg_lector_if.sv
// rtl/module_7seg_lector_if.sv - display-side pins and decoded outputs of the 7-segment reader (err_cnt_o under SEG7_LECTOR_ERRCNT_EN)
interface module_7seg_lector_if #(
    parameter int N_DIGITS  = 4
`ifdef SEG7_LECTOR_ERRCNT_EN
    ,
    parameter int ERR_CNT_W = 8
`endif
);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [N_DIGITS-1:0]   anodo_n;
    logic [6:0]            seg_n;
    logic [4*N_DIGITS-1:0] digits_o;
    logic [N_DIGITS-1:0]   digit_valid_o;
    logic                  update_o;
    logic [IDX_W-1:0]      update_idx_o;
    logic                  err_o;
`ifdef SEG7_LECTOR_ERRCNT_EN
    logic [ERR_CNT_W-1:0]  err_cnt_o;
`endif

    modport master (
`ifdef SEG7_LECTOR_ERRCNT_EN
        input  err_cnt_o,
`endif
        output anodo_n,
        output seg_n,
        input  digits_o,
        input  digit_valid_o,
        input  update_o,
        input  update_idx_o,
        input  err_o
    );

    modport slave (
`ifdef SEG7_LECTOR_ERRCNT_EN
        output err_cnt_o,
`endif
        input  anodo_n,
        input  seg_n,
        output digits_o,
        output digit_valid_o,
        output update_o,
        output update_idx_o,
        output err_o
    );
endinterface

// File: rtl/module_7seg_lector.sv
// rtl/module_7seg_lector.sv - samples a multiplexed common-anode 7-seg display and decodes settled glyphs per digit
// Optional saturating error counter enabled by defining SEG7_LECTOR_ERRCNT_EN.
module module_7seg_lector #(
    parameter int N_DIGITS      = 4,
    parameter int STABLE_CYCLES = 8
`ifdef SEG7_LECTOR_ERRCNT_EN
    ,
    parameter int ERR_CNT_W     = 8
`endif
) (
    input  logic                clk,
    input  logic                rst,
    module_7seg_lector_if.slave bus
);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [N_DIGITS-1:0]   a_meta_q, a_meta_d, sa_q, sa_d;
    logic [6:0]            s_meta_q, s_meta_d, ss_q, ss_d;
    logic [N_DIGITS-1:0]   snap_a_q, snap_a_d;
    logic [6:0]            snap_s_q, snap_s_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [4*N_DIGITS-1:0] digits_q, digits_d;
    logic [N_DIGITS-1:0]   valid_q, valid_d;
    logic                  upd_q, upd_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  err_q, err_d;
`ifdef SEG7_LECTOR_ERRCNT_EN
    logic [ERR_CNT_W-1:0]  errcnt_q, errcnt_d;
`endif

    logic                  sel_legal;
    logic [IDX_W-1:0]      sel_idx;
    logic                  same;
    logic                  rescan;
    logic                  decode_now;
    logic [6:0]            pattern;
    logic [4:0]            glyph;

    // Returns {hit, value}; pattern is active-high {a,b,c,d,e,f,g}.
    function automatic logic [4:0] decode_glyph(input logic [6:0] p);
        case (p)
            7'h7E:   decode_glyph = {1'b1, 4'h0};
            7'h30:   decode_glyph = {1'b1, 4'h1};
            7'h6D:   decode_glyph = {1'b1, 4'h2};
            7'h79:   decode_glyph = {1'b1, 4'h3};
            7'h33:   decode_glyph = {1'b1, 4'h4};
            7'h5B:   decode_glyph = {1'b1, 4'h5};
            7'h5F:   decode_glyph = {1'b1, 4'h6};
            7'h70:   decode_glyph = {1'b1, 4'h7};
            7'h7F:   decode_glyph = {1'b1, 4'h8};
            7'h7B:   decode_glyph = {1'b1, 4'h9};
            7'h77:   decode_glyph = {1'b1, 4'hA};
            7'h1F:   decode_glyph = {1'b1, 4'hB};
            7'h4E:   decode_glyph = {1'b1, 4'hC};
            7'h3D:   decode_glyph = {1'b1, 4'hD};
            7'h4F:   decode_glyph = {1'b1, 4'hE};
            7'h47:   decode_glyph = {1'b1, 4'hF};
            default: decode_glyph = 5'd0;
        endcase
    endfunction

    always_comb begin
        sel_legal = ($countones(~sa_q) == 1);
        sel_idx   = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!sa_q[i]) sel_idx = IDX_W'(i);
        end
        same    = (sa_q == snap_a_q) && (ss_q == snap_s_q);
        pattern = ~ss_q;
        glyph   = decode_glyph(pattern);
    end

    always_comb begin
        a_meta_d   = bus.anodo_n;
        s_meta_d   = bus.seg_n;
        sa_d       = a_meta_q;
        ss_d       = s_meta_q;
        state_d    = state_q;
        snap_a_d   = snap_a_q;
        snap_s_d   = snap_s_q;
        cnt_d      = cnt_q;
        digits_d   = digits_q;
        valid_d    = valid_q;
        upd_d      = 1'b0;
        idx_d      = idx_q;
        err_d      = 1'b0;
`ifdef SEG7_LECTOR_ERRCNT_EN
        errcnt_d   = errcnt_q;
`endif
        rescan     = 1'b0;
        decode_now = 1'b0;

        case (state_q)
            ST_IDLE:  rescan = 1'b1;
            ST_TRACK: begin
                if (same) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                        decode_now = 1'b1;
                        state_d    = ST_DONE;
                    end
                end else begin
                    rescan = 1'b1;
                end
            end
            // A held digit stays here so it is decoded only once per appearance.
            ST_DONE:  rescan = !same;
            default:  state_d = ST_IDLE;
        endcase

        if (rescan) begin
            if (sel_legal) begin
                snap_a_d = sa_q;
                snap_s_d = ss_q;
                cnt_d    = CNT_W'(1);
                state_d  = ST_TRACK;
            end else begin
                cnt_d    = '0;
                state_d  = ST_IDLE;
            end
        end

        if (decode_now) begin
            if (glyph[4]) begin
                digits_d[int'(sel_idx) * 4 +: 4] = glyph[3:0];
                valid_d[sel_idx]                 = 1'b1;
                upd_d                            = 1'b1;
                idx_d                            = sel_idx;
            end else if (pattern != 7'h00) begin
                err_d = 1'b1;
`ifdef SEG7_LECTOR_ERRCNT_EN
                if (errcnt_q != '1) errcnt_d = errcnt_q + ERR_CNT_W'(1);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_meta_q <= '1;
            s_meta_q <= '1;
            sa_q     <= '1;
            ss_q     <= '1;
            state_q  <= ST_IDLE;
            snap_a_q <= '1;
            snap_s_q <= '1;
            cnt_q    <= '0;
            digits_q <= '0;
            valid_q  <= '0;
            upd_q    <= 1'b0;
            idx_q    <= '0;
            err_q    <= 1'b0;
`ifdef SEG7_LECTOR_ERRCNT_EN
            errcnt_q <= '0;
`endif
        end else begin
            a_meta_q <= a_meta_d;
            s_meta_q <= s_meta_d;
            sa_q     <= sa_d;
            ss_q     <= ss_d;
            state_q  <= state_d;
            snap_a_q <= snap_a_d;
            snap_s_q <= snap_s_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            upd_q    <= upd_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
`ifdef SEG7_LECTOR_ERRCNT_EN
            errcnt_q <= errcnt_d;
`endif
        end
    end

    assign bus.digits_o      = digits_q;
    assign bus.digit_valid_o = valid_q;
    assign bus.update_o      = upd_q;
    assign bus.update_idx_o  = idx_q;
    assign bus.err_o         = err_q;
`ifdef SEG7_LECTOR_ERRCNT_EN
    assign bus.err_cnt_o     = errcnt_q;
`endif
endmodule

// File: tb/tb_module_7seg_lector.sv
// tb/tb_module_7seg_lector.sv - randomized bench for module_7seg_lector against a run-length reference model
module tb_module_7seg_lector;
    localparam int N    = 4;
    localparam int S    = 8;
    localparam int MAXC = 16384;

    logic clk = 1'b0;
    logic rst;

    module_7seg_lector_if #(.N_DIGITS(N)) bus ();

    module_7seg_lector #(.N_DIGITS(N), .STABLE_CYCLES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                  7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    // Pin history per cycle and length of the run of identical pin values ending there.
    logic [N-1:0] pa [MAXC];
    logic [6:0]   ps [MAXC];
    bit           pr [MAXC];
    int           runlen [MAXC];
    int           cyc = 0;

    logic [4*N-1:0] m_digits = '0;
    logic [N-1:0]   m_valid  = '0;
    int             m_errcnt = 0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit is_legal(input logic [N-1:0] a);
        int lows = 0;
        for (int i = 0; i < N; i++) if (!a[i]) lows++;
        return lows == 1;
    endfunction

    function automatic int low_index(input logic [N-1:0] a);
        for (int i = 0; i < N; i++) if (!a[i]) return i;
        return 0;
    endfunction

    function automatic int glyph_value(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (glyph_tab[i] == p) return i;
        return -1;
    endfunction

    task automatic check_cycle();
        int  k = cyc;
        bit  e_upd = 0;
        bit  e_err = 0;
        int  e_idx = 0;
        if (pr[k-1]) begin
            m_digits = '0;
            m_valid  = '0;
            m_errcnt = 0;
        end else if (k >= 3) begin
            int j = k - 3;
            if (runlen[j] == S && !pr[j+1] && is_legal(pa[j])) begin
                logic [6:0] pat = ~ps[j];
                int v = glyph_value(pat);
                e_idx = low_index(pa[j]);
                if (v >= 0) begin
                    e_upd = 1;
                    m_digits[e_idx*4 +: 4] = v[3:0];
                    m_valid[e_idx] = 1'b1;
                end else if (pat != 7'h00) begin
                    e_err = 1;
                    if (m_errcnt < 255) m_errcnt++;
                end
            end
        end
        chk("update_o", 32'(bus.update_o), 32'(e_upd));
        chk("err_o", 32'(bus.err_o), 32'(e_err));
        chk("digits_o", 32'(bus.digits_o), 32'(m_digits));
        chk("digit_valid_o", 32'(bus.digit_valid_o), 32'(m_valid));
        if (e_upd) chk("update_idx_o", 32'(bus.update_idx_o), 32'(e_idx));
`ifdef SEG7_LECTOR_ERRCNT_EN
        chk("err_cnt_o", 32'(bus.err_cnt_o), 32'(m_errcnt));
`endif
    endtask

    task automatic step(input logic [N-1:0] a, input logic [6:0] s, input bit r);
        if (cyc >= MAXC - 2) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC - 2);
            $fatal(1, "cycle budget exhausted");
        end
        bus.anodo_n = a;
        bus.seg_n   = s;
        rst         = r;
        pa[cyc] = a;
        ps[cyc] = s;
        pr[cyc] = r;
        if (r) runlen[cyc] = 0;
        else if (cyc > 0 && runlen[cyc-1] > 0 && pa[cyc-1] == a && ps[cyc-1] == s)
            runlen[cyc] = runlen[cyc-1] + 1;
        else runlen[cyc] = 1;
        @(posedge clk);
        #1;
        cyc++;
        check_cycle();
    endtask

    task automatic hold(input logic [N-1:0] a, input logic [6:0] s, input int n);
        for (int i = 0; i < n; i++) step(a, s, 1'b0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(N'($urandom), 7'($urandom), 1'b1);
    endtask

    initial begin
        do_reset(3);
        hold(4'b1111, 7'h7F, 4);
        // Single digit, glyph 3
        hold(4'b1110, ~7'h79, 20);
        // Glyph 1 too short to settle, then glyph 2
        hold(4'b1101, ~7'h30, 5);
        hold(4'b1101, ~7'h6D, 12);
        // Illegal pattern on digit 2
        hold(4'b1011, ~7'h01, 12);
        // Blanking and multi-select never decode
        hold(4'b1100, ~7'h7E, 20);
        hold(4'b1111, ~7'h7E, 20);
        // Full scan, then a second scan interrupted by reset
        for (int d = 0; d < 4; d++) begin
            logic [3:0] one = 4'b0001;
            hold(~(one << d), ~glyph_tab[d+1], 16);
        end
        hold(4'b1110, ~glyph_tab[9], 16);
        hold(4'b1101, ~glyph_tab[10], 8);
        do_reset(2);
        hold(4'b1101, ~glyph_tab[10], 12);
        // Randomized traffic
        for (int seg = 0; seg < 250; seg++) begin
            logic [3:0] a;
            logic [6:0] s;
            logic [3:0] one = 4'b0001;
            int r  = $urandom_range(0, 9);
            int r2 = $urandom_range(0, 19);
            if (r < 8) a = ~(one << $urandom_range(0, 3));
            else a = 4'($urandom_range(0, 15));
            if (r2 < 12) s = ~glyph_tab[$urandom_range(0, 15)];
            else if (r2 < 15) s = 7'h7F;
            else s = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 3));
            hold(a, s, $urandom_range(1, 24));
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
